// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART frame sequencing controller.
package uart_frame_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LEN     = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_CHK     = 3'd3,
        ST_HOLD    = 3'd4
    } state_e;

    localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

    // Width needed to hold a payload byte count of 0..nbytes.
    function automatic int len_w(input int nbytes);
        return $clog2(nbytes + 1);
    endfunction

endpackage

// File: rtl/uart_frame_timeout.sv
// Saturating inter-byte tick counter; expire is a one-cycle strobe on the tick
// that would take the count past TICKS-1 with no clearing byte that cycle.
module uart_frame_timeout #(
    parameter int TICKS = 4096
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    input  logic clr,
    input  logic tick,
    output logic expire
);

    localparam int CW = (TICKS > 2) ? $clog2(TICKS) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICKS - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d  = cnt_q;
        expire = en && !clr && tick && (cnt_q == LAST);
        if (!en || clr) begin
            cnt_d = '0;
        end else if (tick && (cnt_q != LAST)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_frame_ctrl.sv
// Assembles SYNC/LEN/payload/CHK frames from the UART receiver into operands
// offered to the RSA core on a valid/ready handshake.
module uart_frame_ctrl
    import uart_frame_pkg::*;
#(
    parameter int              DBIT          = 8,
    parameter int              NBYTES        = 4,
    parameter logic [DBIT-1:0] SYNC          = DBIT'(SYNC_DEFAULT),
    parameter int              TIMEOUT_TICKS = 4096
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         s_tick,
    input  logic                         rx_done_tick,
    input  logic [DBIT-1:0]              rx_data,
    input  logic                         frame_ready,
    output logic                         frame_valid,
    output logic [NBYTES*DBIT-1:0]       frame_data,
    output logic [len_w(NBYTES)-1:0]     frame_len,
    output logic                         busy,
    output logic                         err_len,
    output logic                         err_chk,
    output logic                         err_timeout,
    output logic                         overrun
);

    localparam int FW = NBYTES * DBIT;
    localparam int LW = len_w(NBYTES);
    localparam logic [DBIT-1:0] NB_D = DBIT'(NBYTES);

    state_e          state_q, state_d;
    logic [FW-1:0]   shift_q, shift_d;
    logic [FW-1:0]   frame_data_q, frame_data_d;
    logic [LW-1:0]   len_q, len_d;
    logic [LW-1:0]   cnt_q, cnt_d;
    logic [LW-1:0]   frame_len_q, frame_len_d;
    logic [DBIT-1:0] chk_q, chk_d;
    logic            frame_valid_q, frame_valid_d;
    logic            err_len_q, err_len_d;
    logic            err_chk_q, err_chk_d;
    logic            err_timeout_q, err_timeout_d;
    logic            overrun_q, overrun_d;
    logic            to_en, to_expire;

    // The counter idles at zero outside LEN/PAYLOAD/CHK, so every state entry starts it fresh.
    assign to_en = (state_q == ST_LEN) || (state_q == ST_PAYLOAD) || (state_q == ST_CHK);

    uart_frame_timeout #(
        .TICKS (TIMEOUT_TICKS)
    ) u_timeout (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (to_en),
        .clr     (rx_done_tick),
        .tick    (s_tick),
        .expire  (to_expire)
    );

    always_comb begin
        state_d       = state_q;
        shift_d       = shift_q;
        len_d         = len_q;
        cnt_d         = cnt_q;
        chk_d         = chk_q;
        frame_data_d  = frame_data_q;
        frame_len_d   = frame_len_q;
        frame_valid_d = frame_valid_q;
        err_len_d     = 1'b0;
        err_chk_d     = 1'b0;
        err_timeout_d = 1'b0;
        overrun_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rx_done_tick && (rx_data == SYNC)) state_d = ST_LEN;
            end
            ST_LEN: begin
                if (rx_done_tick) begin
                    if ((rx_data != '0) && (rx_data <= NB_D)) begin
                        len_d   = LW'(rx_data);
                        chk_d   = rx_data;
                        shift_d = '0;
                        cnt_d   = '0;
                        state_d = ST_PAYLOAD;
                    end else begin
                        err_len_d = 1'b1;
                        state_d   = ST_IDLE;
                    end
                end else if (to_expire) begin
                    err_timeout_d = 1'b1;
                    state_d       = ST_IDLE;
                end
            end
            ST_PAYLOAD: begin
                if (rx_done_tick) begin
                    shift_d = (shift_q << DBIT) | FW'(rx_data);
                    chk_d   = chk_q ^ rx_data;
                    cnt_d   = cnt_q + LW'(1);
                    if (cnt_d == len_q) state_d = ST_CHK;
                end else if (to_expire) begin
                    err_timeout_d = 1'b1;
                    state_d       = ST_IDLE;
                end
            end
            ST_CHK: begin
                if (rx_done_tick) begin
                    if (rx_data == chk_q) begin
                        frame_data_d  = shift_q;
                        frame_len_d   = len_q;
                        frame_valid_d = 1'b1;
                        state_d       = ST_HOLD;
                    end else begin
                        err_chk_d = 1'b1;
                        state_d   = ST_IDLE;
                    end
                end else if (to_expire) begin
                    err_timeout_d = 1'b1;
                    state_d       = ST_IDLE;
                end
            end
            ST_HOLD: begin
                // Bytes are dropped here, including one landing in the accept cycle.
                overrun_d = rx_done_tick;
                if (frame_ready) begin
                    frame_valid_d = 1'b0;
                    state_d       = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            shift_q       <= '0;
            len_q         <= '0;
            cnt_q         <= '0;
            chk_q         <= '0;
            frame_data_q  <= '0;
            frame_len_q   <= '0;
            frame_valid_q <= 1'b0;
            err_len_q     <= 1'b0;
            err_chk_q     <= 1'b0;
            err_timeout_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            shift_q       <= shift_d;
            len_q         <= len_d;
            cnt_q         <= cnt_d;
            chk_q         <= chk_d;
            frame_data_q  <= frame_data_d;
            frame_len_q   <= frame_len_d;
            frame_valid_q <= frame_valid_d;
            err_len_q     <= err_len_d;
            err_chk_q     <= err_chk_d;
            err_timeout_q <= err_timeout_d;
            overrun_q     <= overrun_d;
        end
    end

    assign frame_valid = frame_valid_q;
    assign frame_data  = frame_data_q;
    assign frame_len   = frame_len_q;
    assign busy        = (state_q != ST_IDLE);
    assign err_len     = err_len_q;
    assign err_chk     = err_chk_q;
    assign err_timeout = err_timeout_q;
    assign overrun     = overrun_q;

endmodule
